// File: rtl/z_stream_monitor.sv
// z_stream_monitor
// Watches the qualified serial Z stream from the sequentialDemo stage. It detects a fixed
// pattern (overlapping matches allowed) and keeps saturating statistics.
//
// Ports:
//   CLK        clock, all state updates on posedge
//   RST        synchronous active-high reset
//   Z          serial data bit
//   Z_VALID    Z is sampled only when high
//   CLR        synchronous clear, same effect as RST (RST has priority)
//   MATCH      one-cycle pulse, registered, the cycle after the completing sample
//   MATCH_CNT  saturating match count
//   RISE_CNT   saturating count of 0->1 transitions between valid samples
//   RUN_MAX    saturating longest run of consecutive valid ones
//   STATE      00 FILL, 01 RUN, 10 SAT
module z_stream_monitor #(
  parameter int unsigned           PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0]  PATTERN   = 4'b1011,
  parameter int unsigned           CNT_W     = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Z,
  input  logic             Z_VALID,
  input  logic             CLR,
  output logic             MATCH,
  output logic [CNT_W-1:0] MATCH_CNT,
  output logic [CNT_W-1:0] RISE_CNT,
  output logic [CNT_W-1:0] RUN_MAX,
  output logic [1:0]       STATE
);

  localparam int unsigned      FillW    = $clog2(PATTERN_W + 1);
  localparam logic [FillW-1:0] FillFull = FillW'(PATTERN_W);
  localparam logic [FillW-1:0] FillLast = FillW'(PATTERN_W - 1);
  localparam logic [CNT_W-1:0] CntMax   = '1;

  typedef enum logic [1:0] {
    StFill = 2'b00,
    StRun  = 2'b01,
    StSat  = 2'b10
  } state_e;

  state_e               state_q, state_d;
  logic [PATTERN_W-1:0] win_q, win_d;
  logic [FillW-1:0]     fill_q, fill_d;
  logic                 match_q, match_d;
  logic [CNT_W-1:0]     match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0]     rise_cnt_q, rise_cnt_d;
  logic [CNT_W-1:0]     run_q, run_d;
  logic [CNT_W-1:0]     run_max_q, run_max_d;
  logic                 prev_q, prev_d;

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    fill_d      = fill_q;
    match_d     = 1'b0;
    match_cnt_d = match_cnt_q;
    rise_cnt_d  = rise_cnt_q;
    run_d       = run_q;
    run_max_d   = run_max_q;
    prev_d      = prev_q;

    if (CLR) begin
      state_d     = StFill;
      win_d       = '0;
      fill_d      = '0;
      match_cnt_d = '0;
      rise_cnt_d  = '0;
      run_d       = '0;
      run_max_d   = '0;
      prev_d      = 1'b0;
    end else if (Z_VALID) begin
      win_d = {win_q[PATTERN_W-2:0], Z};
      if (fill_q != FillFull) begin
        fill_d = fill_q + 1'b1;
      end
      // Only a window filled entirely with samples since the last clear may match.
      match_d = (win_d == PATTERN) && (fill_q >= FillLast);
      if (match_d && (match_cnt_q != CntMax)) begin
        match_cnt_d = match_cnt_q + 1'b1;
      end
      if (Z && !prev_q && (rise_cnt_q != CntMax)) begin
        rise_cnt_d = rise_cnt_q + 1'b1;
      end
      prev_d = Z;
      if (Z) begin
        run_d = (run_q == CntMax) ? run_q : run_q + 1'b1;
      end else begin
        run_d = '0;
      end
      if (run_d > run_max_q) begin
        run_max_d = run_d;
      end

      case (state_q)
        StFill: begin
          if (fill_d == FillFull) begin
            state_d = (match_cnt_d == CntMax) ? StSat : StRun;
          end
        end
        StRun: begin
          if (match_cnt_d == CntMax) begin
            state_d = StSat;
          end
        end
        StSat:   state_d = StSat;
        default: state_d = StFill;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StFill;
      win_q       <= '0;
      fill_q      <= '0;
      match_q     <= 1'b0;
      match_cnt_q <= '0;
      rise_cnt_q  <= '0;
      run_q       <= '0;
      run_max_q   <= '0;
      prev_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      match_cnt_q <= match_cnt_d;
      rise_cnt_q  <= rise_cnt_d;
      run_q       <= run_d;
      run_max_q   <= run_max_d;
      prev_q      <= prev_d;
    end
  end

  assign MATCH     = match_q;
  assign MATCH_CNT = match_cnt_q;
  assign RISE_CNT  = rise_cnt_q;
  assign RUN_MAX   = run_max_q;
  assign STATE     = state_q;

endmodule

// File: tb/tb_z_stream_monitor.sv
// Bench for z_stream_monitor: two instances (CNT_W=8 and CNT_W=2) share one stimulus stream.
// The driver pushes the expected post-edge snapshot for every cycle; a monitor pops and
// compares shortly after each rising edge. Hand-computed checks cover the headline numbers.
module tb_z_stream_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       z = 1'b0;
  logic       z_valid = 1'b0;

  logic       match8;
  logic [7:0] mcnt8, rcnt8, rmax8;
  logic [1:0] st8;
  logic       match2;
  logic [1:0] mcnt2, rcnt2, rmax2;
  logic [1:0] st2;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  z_stream_monitor u_dut8 (
    .CLK       (clk),
    .RST       (rst),
    .Z         (z),
    .Z_VALID   (z_valid),
    .CLR       (clr),
    .MATCH     (match8),
    .MATCH_CNT (mcnt8),
    .RISE_CNT  (rcnt8),
    .RUN_MAX   (rmax8),
    .STATE     (st8)
  );

  z_stream_monitor #(.CNT_W(2)) u_dut2 (
    .CLK       (clk),
    .RST       (rst),
    .Z         (z),
    .Z_VALID   (z_valid),
    .CLR       (clr),
    .MATCH     (match2),
    .MATCH_CNT (mcnt2),
    .RISE_CNT  (rcnt2),
    .RUN_MAX   (rmax2),
    .STATE     (st2)
  );

  typedef struct {
    int n;
    int m8, mc8, rc8, rm8, st8;
    int m2, mc2, rc2, rm2, st2;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: full history of valid bits since the last clear.
  bit hist[$];
  int mcnt[2];
  int rcnt[2];
  int rmax[2];
  int mx[2] = '{255, 3};
  int cyc_n = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act == exp_v) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
  endtask

  function automatic int st_of(input int k);
    if (hist.size() < 4) return 0;
    return (mcnt[k] == mx[k]) ? 2 : 1;
  endfunction

  task automatic cyc(input bit r, input bit c, input bit v, input bit zb);
    exp_t e;
    int   mm;
    int   tr;
    bit   pv;
    @(negedge clk);
    rst = r;
    clr = c;
    z_valid = v;
    z = zb;
    cyc_n++;
    mm = 0;
    if (r || c) begin
      hist.delete();
      for (int k = 0; k < 2; k++) begin
        mcnt[k] = 0;
        rcnt[k] = 0;
        rmax[k] = 0;
      end
    end else if (v) begin
      pv = (hist.size() > 0) ? hist[hist.size()-1] : 1'b0;
      hist.push_back(zb);
      if (hist.size() >= 4) begin
        if (hist[hist.size()-4] == 1'b1 && hist[hist.size()-3] == 1'b0 &&
            hist[hist.size()-2] == 1'b1 && hist[hist.size()-1] == 1'b1) mm = 1;
      end
      tr = 0;
      for (int i = hist.size() - 1; i >= 0; i--) begin
        if (!hist[i]) break;
        tr++;
      end
      for (int k = 0; k < 2; k++) begin
        if (mm == 1 && mcnt[k] < mx[k]) mcnt[k]++;
        if (zb && !pv && rcnt[k] < mx[k]) rcnt[k]++;
        if (((tr < mx[k]) ? tr : mx[k]) > rmax[k]) rmax[k] = (tr < mx[k]) ? tr : mx[k];
      end
    end
    e.n = cyc_n;
    e.m8 = mm;  e.mc8 = mcnt[0]; e.rc8 = rcnt[0]; e.rm8 = rmax[0]; e.st8 = st_of(0);
    e.m2 = mm;  e.mc2 = mcnt[1]; e.rc2 = rcnt[1]; e.rm2 = rmax[1]; e.st2 = st_of(1);
    exp_q.push_back(e);
  endtask

  task automatic send(input bit zb);
    cyc(1'b0, 1'b0, 1'b1, zb);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic hand8(input string t, input int mc, input int rc, input int rm, input int st);
    chk({t, "_match_cnt"}, int'(mcnt8), mc);
    chk({t, "_rise_cnt"}, int'(rcnt8), rc);
    chk({t, "_run_max"}, int'(rmax8), rm);
    chk({t, "_state"}, int'(st8), st);
  endtask

  // Monitor: compare both instances a little after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (int'(match8) != e.m8) $display("FAIL sb8_match cyc %0d: got %0d, expected %0d", e.n, match8, e.m8);
        if (int'(mcnt8) != e.mc8) $display("FAIL sb8_match_cnt cyc %0d: got %0d, expected %0d", e.n, mcnt8, e.mc8);
        if (int'(rcnt8) != e.rc8) $display("FAIL sb8_rise_cnt cyc %0d: got %0d, expected %0d", e.n, rcnt8, e.rc8);
        if (int'(rmax8) != e.rm8) $display("FAIL sb8_run_max cyc %0d: got %0d, expected %0d", e.n, rmax8, e.rm8);
        if (int'(st8) != e.st8) $display("FAIL sb8_state cyc %0d: got %0d, expected %0d", e.n, st8, e.st8);
        if (int'(match2) != e.m2) $display("FAIL sb2_match cyc %0d: got %0d, expected %0d", e.n, match2, e.m2);
        if (int'(mcnt2) != e.mc2) $display("FAIL sb2_match_cnt cyc %0d: got %0d, expected %0d", e.n, mcnt2, e.mc2);
        if (int'(rcnt2) != e.rc2) $display("FAIL sb2_rise_cnt cyc %0d: got %0d, expected %0d", e.n, rcnt2, e.rc2);
        if (int'(rmax2) != e.rm2) $display("FAIL sb2_run_max cyc %0d: got %0d, expected %0d", e.n, rmax2, e.rm2);
        if (int'(st2) != e.st2) $display("FAIL sb2_state cyc %0d: got %0d, expected %0d", e.n, st2, e.st2);
        total += 10;
        passed += int'(int'(match8) == e.m8) + int'(int'(mcnt8) == e.mc8) +
                  int'(int'(rcnt8) == e.rc8) + int'(int'(rmax8) == e.rm8) +
                  int'(int'(st8) == e.st8) + int'(int'(match2) == e.m2) +
                  int'(int'(mcnt2) == e.mc2) + int'(int'(rcnt2) == e.rc2) +
                  int'(int'(rmax2) == e.rm2) + int'(int'(st2) == e.st2);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit t2[7] = '{1, 0, 1, 1, 0, 1, 1};
    bit t5[4] = '{1, 0, 1, 1};

    // 1: reset with random inputs
    repeat (2) cyc(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    idle();
    chk("t1_match", int'(match8), 0);
    hand8("t1", 0, 0, 0, 0);

    // 2: back-to-back valid samples
    foreach (t2[i]) send(t2[i]);
    idle();
    hand8("t2", 2, 3, 2, 1);

    // 3: same bits with gaps of 1-3 cycles
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    foreach (t2[i]) begin
      send(t2[i]);
      repeat ($urandom_range(1, 3)) idle();
    end
    hand8("t3", 2, 3, 2, 1);

    // 4: saturation of the narrow instance
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    foreach (t5[i]) send(t5[i]);
    for (int r = 0; r < 3; r++) begin
      send(1'b0); send(1'b1); send(1'b1);
      if (r == 1) begin
        idle();
        chk("t4_cnt2_after_10", int'(mcnt2), 3);
        chk("t4_state2_after_10", int'(st2), 2);
      end
    end
    idle();
    chk("t4_match2_after_sat", int'(match2), 1);
    chk("t4_cnt2_held", int'(mcnt2), 3);
    chk("t4_cnt8", int'(mcnt8), 4);

    // 5: clear with a valid sample pending
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send(1'b1); send(1'b0); send(1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    idle();
    chk("t5_match", int'(match8), 0);
    hand8("t5_clr", 0, 0, 0, 0);
    send(1'b1);
    foreach (t5[i]) send(t5[i]);
    idle();
    chk("t5_cnt8", int'(mcnt8), 1);

    // 6: long run
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (10) send(1'b1);
    idle();
    chk("t6_run_max_10", int'(rmax8), 10);
    send(1'b0);
    repeat (3) send(1'b1);
    idle();
    chk("t6_run_max_held", int'(rmax8), 10);
    chk("t6_rise_cnt", int'(rcnt8), 2);
    chk("t6_run_max2_sat", int'(rmax2), 3);

    @(posedge clk);
    #5;
    chk("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/z_stream_monitor.md
Name: z_stream_monitor

Overview:
- Downstream consumer of the single-bit Z output of the sequentialDemo stage.
- Samples Z as a qualified serial stream and detects a fixed multi-bit pattern, with overlapping matches allowed.
- Also keeps saturating statistics: match count, rising-edge count and longest run of ones.
- Feeds status/debug logic; one clock domain (CLK), synchronous active-high reset.

Parameters:
- PATTERN_W, 4, pattern length in bits (must be >= 2).
- PATTERN, 4'b1011, target pattern; MSB is the oldest sample.
- CNT_W, 8, width of all counters (must be >= 2).

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST  input  1  synchronous active-high reset.
- Z  input  1  serial data bit from the upstream stage.
- Z_VALID  input  1  Z is sampled only when high.
- CLR  input  1  synchronous clear of all state (same effect as RST).
- MATCH  output  1  one-cycle pulse: pattern just completed.
- MATCH_CNT  output  CNT_W  saturating number of matches.
- RISE_CNT  output  CNT_W  saturating number of 0->1 transitions between valid samples.
- RUN_MAX  output  CNT_W  saturating longest run of consecutive valid 1s.
- STATE  output  2  FSM state: 00 FILL, 01 RUN, 10 SAT.

Behaviour:
- Priority: RST > CLR > Z_VALID.
- RST or CLR high at an edge clears everything: window shift register, fill counter, MATCH, MATCH_CNT, RISE_CNT, current run, RUN_MAX and prev-bit all go to 0; STATE = FILL.
  - The Z sample presented in that cycle is discarded.
- Z_VALID=0:
  - No state changes except MATCH, which is forced to 0.
  - Gaps are invisible to pattern, run and edge tracking.
- Z_VALID=1, at the edge:
  - window <= {window[PATTERN_W-2:0], Z}.
  - Fill counter increments, saturating at PATTERN_W.
- Match condition:
  - The new window equals PATTERN and the fill counter was >= PATTERN_W-1 before this sample.
  - On a match, MATCH=1 in the following cycle only (registered, latency 1 edge); MATCH=0 otherwise.
  - Overlap: window bits are never flushed on a match.
- MATCH_CNT: +1 per match, saturating at 2^CNT_W-1. MATCH keeps pulsing after saturation.
- RISE_CNT: +1 when Z=1 and prev=0, saturating.
  - prev updates only on valid samples.
  - prev resets to 0, so a first valid 1 counts as a rise.
- Runs:
  - run <= Z ? sat(run+1) : 0.
  - RUN_MAX <= max(RUN_MAX, run_next) on the same edge, so RUN_MAX is current with no extra latency.
- FSM transitions:
  - FILL -> RUN on the valid sample that brings the fill counter to PATTERN_W.
  - RUN -> SAT on the edge where MATCH_CNT becomes 2^CNT_W-1.
  - SAT holds until RST or CLR; STATE=11 is never produced.
  - Matching requires a full window, so a match cannot occur in FILL.
- Saturation: all counters clamp at max and never wrap.
- Mid-operation reset: a partial pattern in the window is lost and the window must refill before any match.

Test Plan (PATTERN=1011, CNT_W=8 unless stated):
1. RST high 2 cycles with random Z/Z_VALID -> MATCH=0, all counters 0, STATE=00.
2. Valid every cycle, Z=1,0,1,1,0,1,1 -> STATE=01 after sample 4; MATCH high the cycle after samples 4 and 7 only; final MATCH_CNT=2, RISE_CNT=3, RUN_MAX=2.
3. Same bits as 2 with Z_VALID low 1-3 cycles between bits, Z toggling randomly in the gaps -> identical final counts; each MATCH pulse follows its completing valid sample by one cycle.
4. CNT_W=2: stream 1011 followed by 011 repeated -> matches after samples 4, 7, 10; MATCH_CNT=3 and STATE=10 after sample 10; fourth match at sample 13 still pulses MATCH, MATCH_CNT stays 3.
5. Z=1,0,1, then CLR=1 with Z_VALID=1, Z=1 -> all zero, STATE=00; next valid 1 gives no MATCH; 1,0,1,1 afterwards matches once.
6. Ten valid 1s, one 0, three 1s -> RUN_MAX=10 after sample 10 and stays 10; RISE_CNT=2.
